// File: rtl/decode_sdiv_65s_26s_40_seq.sv
// Iterative restoring signed divider: 65-bit dividend / 26-bit divisor -> saturated
// 40-bit quotient plus remainder, one quotient bit per enabled clock.
module decode_sdiv_65s_26s_40_seq #(
    parameter int din0_WIDTH = 65,
    parameter int din1_WIDTH = 26,
    parameter int dout_WIDTH = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div0,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(din0_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(din0_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [din0_WIDTH-1:0] POS_LIM =
        {{(din0_WIDTH-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
    localparam logic [din0_WIDTH-1:0] NEG_LIM =
        {{(din0_WIDTH-dout_WIDTH){1'b0}}, 1'b1, {(dout_WIDTH-1){1'b0}}};
    localparam logic [dout_WIDTH-1:0] DOUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] DOUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [din0_WIDTH-1:0]   dvd_q, dvd_d;
    logic [din1_WIDTH-1:0]   dvs_q, dvs_d;
    logic [din1_WIDTH-1:0]   prem_q, prem_d;
    logic                    qsign_q, qsign_d;
    logic                    rsign_q, rsign_d;
    logic                    div0_pend_q, div0_pend_d;
    logic                    out_valid_q, out_valid_d;
    logic [dout_WIDTH-1:0]   dout_q, dout_d;
    logic [din1_WIDTH-1:0]   rem_q, rem_d;
    logic                    div0_q, div0_d;
    logic                    ovf_q, ovf_d;

    logic [din0_WIDTH-1:0]   din0_mag_s;
    logic [din1_WIDTH-1:0]   din1_mag_s;
    logic [din1_WIDTH:0]     shift_s;
    logic [din1_WIDTH-1:0]   diff_s;
    logic                    ge_s;
    logic                    pos_ovf_s;
    logic                    neg_ovf_s;
    logic                    accept_s;

    // Magnitudes: dividend kept at full width so -2^64 maps to +2^64.
    assign din0_mag_s = din0[din0_WIDTH-1] ? -din0 : din0;
    assign din1_mag_s = din1[din1_WIDTH-1] ? -din1 : din1;

    // The shifted remainder carries one extra bit so the compare cannot overflow;
    // the difference always fits back into din1_WIDTH bits when it is taken.
    assign shift_s   = {prem_q, dvd_q[din0_WIDTH-1]};
    assign ge_s      = (shift_s >= {1'b0, dvs_q});
    assign diff_s    = shift_s[din1_WIDTH-1:0] - dvs_q;
    assign pos_ovf_s = (dvd_q > POS_LIM);
    assign neg_ovf_s = (dvd_q > NEG_LIM);

    assign in_ready  = ce & (state_q == S_IDLE) & ~reset;
    assign accept_s  = in_valid & in_ready;

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign rem       = rem_q;
    assign div0      = div0_q;
    assign ovf       = ovf_q;

    // Next-state and datapath; everything holds while ce is low.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        qsign_d     = qsign_q;
        rsign_d     = rsign_q;
        div0_pend_d = div0_pend_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        rem_d       = rem_q;
        div0_d      = div0_q;
        ovf_d       = ovf_q;
        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        qsign_d     = din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                        rsign_d     = din0[din0_WIDTH-1];
                        dvd_d       = din0_mag_s;
                        dvs_d       = din1_mag_s;
                        prem_d      = '0;
                        cnt_d       = CNT_LAST;
                        div0_pend_d = (din1 == '0);
                        state_d     = (din1 == '0) ? S_FIX : S_CALC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    // Quotient bits shift into the vacated LSBs of the dividend register.
                    if (ge_s) begin
                        prem_d = diff_s;
                        dvd_d  = {dvd_q[din0_WIDTH-2:0], 1'b1};
                    end else begin
                        prem_d = shift_s[din1_WIDTH-1:0];
                        dvd_d  = {dvd_q[din0_WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                        state_d = S_CALC;
                    end
                end
                S_FIX: begin
                    if (div0_pend_q) begin
                        dout_d = rsign_q ? DOUT_MIN : DOUT_MAX;
                        rem_d  = '0;
                        div0_d = 1'b1;
                        ovf_d  = 1'b0;
                    end else if (!qsign_q && pos_ovf_s) begin
                        dout_d = DOUT_MAX;
                        rem_d  = rsign_q ? -prem_q : prem_q;
                        div0_d = 1'b0;
                        ovf_d  = 1'b1;
                    end else if (qsign_q && neg_ovf_s) begin
                        dout_d = DOUT_MIN;
                        rem_d  = rsign_q ? -prem_q : prem_q;
                        div0_d = 1'b0;
                        ovf_d  = 1'b1;
                    end else begin
                        dout_d = qsign_q ? -dvd_q[dout_WIDTH-1:0] : dvd_q[dout_WIDTH-1:0];
                        rem_d  = rsign_q ? -prem_q : prem_q;
                        div0_d = 1'b0;
                        ovf_d  = 1'b0;
                    end
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers; reset aborts any division in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            qsign_q     <= 1'b0;
            rsign_q     <= 1'b0;
            div0_pend_q <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            rem_q       <= '0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            qsign_q     <= qsign_d;
            rsign_q     <= rsign_d;
            div0_pend_q <= div0_pend_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            rem_q       <= rem_d;
            div0_q      <= div0_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_decode_sdiv_65s_26s_40_seq.sv
// Directed bench for decode_sdiv_65s_26s_40_seq: signs, divide by zero, saturation,
// latency, output hold, ce stall, back-to-back handshake and asynchronous reset.
module tb_decode_sdiv_65s_26s_40_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [64:0] din0;
    logic [25:0] din1;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] dout;
    logic [25:0] rem;
    logic        div0;
    logic        ovf;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    decode_sdiv_65s_26s_40_seq dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .rem       (rem),
        .div0      (div0),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle. latency counts cycles from the
    // accept cycle to the first cycle showing out_valid.
    task automatic run_div(input string tag, input logic [64:0] a, input logic [25:0] b,
                           input logic [39:0] eq, input logic [25:0] er,
                           input logic ed0, input logic eovf, input int elat,
                           input int hold, input int stall_at);
        int n;
        din0     = a;
        din1     = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din0     = ~a;
        din1     = ~b;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 300) begin
            if (stall_at > 0 && n == stall_at) ce = 1'b0;
            if (stall_at > 0 && n == stall_at + 5) ce = 1'b1;
            @(negedge clk);
            n++;
        end
        ce = 1'b1;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_lat"},   64'(n),         64'(elat));
        chk({tag, "_dout"},  64'(dout),      64'(eq));
        chk({tag, "_rem"},   64'(rem),       64'(er));
        chk({tag, "_div0"},  64'(div0),      64'(ed0));
        chk({tag, "_ovf"},   64'(ovf),       64'(eovf));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_dout"},  64'(dout),      64'(eq));
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_ready"}, 64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        chk({tag, "_done_ready"}, 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_taken"},    64'(out_valid), 64'd0);
        chk({tag, "_next_rdy"}, 64'(in_ready),  64'd1);
    endtask

    initial begin
        reset     = 1'b1;
        ce        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        #2;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_dout",  64'(dout),      64'd0);
        chk("rst_rem",   64'(rem),       64'd0);
        chk("rst_div0",  64'(div0),      64'd0);
        chk("rst_ovf",   64'(ovf),       64'd0);
        chk("rst_ready", 64'(in_ready),  64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_div("pp",      65'd100,   26'd7,   40'd14,   26'd2,   1'b0, 1'b0, 67, 10, 0);
        run_div("np",     -65'sd100,  26'd7,  -40'sd14, -26'sd2,  1'b0, 1'b0, 67, 0, 0);
        run_div("pn",      65'd100,  -26'sd7, -40'sd14,  26'd2,   1'b0, 1'b0, 67, 0, 0);
        run_div("nn",     -65'sd100, -26'sd7,  40'd14,  -26'sd2,  1'b0, 1'b0, 67, 0, 0);
        run_div("zp",      65'd5,     26'd0,   40'h7F_FFFF_FFFF, 26'd0, 1'b1, 1'b0, 2, 0, 0);
        run_div("zn",     -65'sd5,    26'd0,   40'h80_0000_0000, 26'd0, 1'b1, 1'b0, 2, 0, 0);
        run_div("sat_pos", 65'h4_0000_0000_0000, 26'd1,
                40'h7F_FFFF_FFFF, 26'd0, 1'b0, 1'b1, 67, 0, 0);
        run_div("sat_min", 65'h1_0000_0000_0000_0000, 26'h3FF_FFFF,
                40'h7F_FFFF_FFFF, 26'd0, 1'b0, 1'b1, 67, 0, 0);
        run_div("neg_lim", 65'h1_FFFF_FF80_0000_0000, 26'd1,
                40'h80_0000_0000, 26'd0, 1'b0, 1'b0, 67, 0, 0);
        run_div("neg_sat", 65'h1_FFFF_FF7F_FFFF_FFFF, 26'd1,
                40'h80_0000_0000, 26'd0, 1'b0, 1'b1, 67, 0, 0);
        run_div("stall",   65'd100,   26'd7,   40'd14,   26'd2,   1'b0, 1'b0, 72, 0, 20);

        // Start 100/7, then reset mid-CALC between clock edges.
        din0     = 65'd100;
        din1     = 26'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_dout",  64'(dout),      64'd0);
        chk("arst_ready", 64'(in_ready),  64'd0);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_idle",  64'(in_ready),  64'd1);
        @(negedge clk);
        chk("arst_novalid", 64'(out_valid), 64'd0);
        run_div("post_rst", 65'd1000, -26'sd3, -40'sd333, 26'd1, 1'b0, 1'b0, 67, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
